// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding and the
// saturation value of the edge counter as a function of its width.
package freq_meter_pkg;

   typedef enum logic {
      S_WARM = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // All-ones value of a w-bit counter; the edge counter stops here.
   function automatic int unsigned sat_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer plus a third register for rising-edge detection of
// an asynchronous input. Also intended for button inputs elsewhere.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d_async,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d_async;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of a slow external signal over a fixed gate window of
// M clk cycles and latches the (saturating) count once per window.
//
//   state  | meaning
//   S_WARM | first window after reset or en rising; result discarded
//   S_RUN  | every completed window latches freq/ovf and pulses valid
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int N = 29,
   parameter int M = 50000000,
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         sig_in,
   output logic [W-1:0] freq,
   output logic         valid,
   output logic         ovf
);

   localparam logic [N-1:0] LAST = N'(M - 1);
   localparam logic [W-1:0] SAT  = W'(sat_max(W));

   state_t       state;
   logic [N-1:0] gate_cnt;
   logic [W-1:0] edge_cnt;
   logic [W-1:0] edge_sum;
   logic         rise;
   logic         win_end;

   sync_edge u_sync (
      .clk     (clk),
      .reset   (reset),
      .d_async (sig_in),
      .rise    (rise)
   );

   assign win_end = (gate_cnt == LAST);

   // Edge count including this cycle's edge, held at the all-ones value.
   always_comb begin
      edge_sum = edge_cnt;
      if (rise && (edge_cnt != SAT)) begin
         edge_sum = edge_cnt + W'(1);
      end
   end

   // Window FSM, gate/edge counters and registered results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_WARM;
         gate_cnt <= '0;
         edge_cnt <= '0;
         freq     <= '0;
         ovf      <= 1'b0;
         valid    <= 1'b0;
      end else if (!en) begin
         state    <= S_WARM;
         gate_cnt <= '0;
         edge_cnt <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (win_end) begin
            gate_cnt <= '0;
            // An edge on the closing cycle belongs to the closing window.
            edge_cnt <= '0;
            if (state == S_RUN) begin
               freq  <= edge_sum;
               ovf   <= (edge_sum == SAT);
               valid <= 1'b1;
            end else begin
               state <= S_RUN;
            end
         end else begin
            gate_cnt <= gate_cnt + N'(1);
            edge_cnt <= edge_sum;
         end
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (W=8 and W=4) share stimulus;
// expected results are queued when stimulus is set up and compared on valid.
module tb_freq_meter;

   localparam int M = 100;

   typedef struct {
      int cyc;
      int f8;
      int o8;
      int f4;
      int o4;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic       sig_in = 1'b0;
   logic [7:0] freq8;
   logic       valid8;
   logic       ovf8;
   logic [3:0] freq4;
   logic       valid4;
   logic       ovf4;

   int   cyc = 0;
   int   mode = 0;       // 0: level, 1: periodic, 2: single pulse
   logic lvl = 1'b0;
   int   per = 10;
   int   pulse_k = 198;
   int   n_pass = 0;
   int   n_total = 0;
   exp_t sb[$];

   freq_meter #(.N(29), .M(M), .W(8)) u_dut8 (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sig_in (sig_in),
      .freq   (freq8),
      .valid  (valid8),
      .ovf    (ovf8)
   );

   freq_meter #(.N(29), .M(M), .W(4)) u_dut4 (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .sig_in (sig_in),
      .freq   (freq4),
      .valid  (valid4),
      .ovf    (ovf4)
   );

   always #5 clk = ~clk;

   // cyc = number of clk edges since reset was last released.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // sig_in driven on the falling edge; value before edge k uses cyc = k-1.
   always @(negedge clk) begin
      case (mode)
         1:       sig_in = ((cyc % per) < (per / 2));
         2:       sig_in = (cyc == pulse_k - 1);
         default: sig_in = lvl;
      endcase
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Scoreboard: every valid pulse must match the next queued result.
   always @(negedge clk) begin
      if (valid8 || valid4) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", int'(valid8), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("valid4_match", int'(valid4), int'(valid8));
            chk("freq8", int'(freq8), e.f8);
            chk("ovf8", int'(ovf8), e.o8);
            chk("freq4", int'(freq4), e.f4);
            chk("ovf4", int'(ovf4), e.o4);
         end
      end
   end

   task automatic go_to(input int n);
      int budget;
      budget = 3000;
      while (cyc != n && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      if (cyc != n) chk("go_to_timeout", cyc, n);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic push(input int c, input int f8, input int o8,
                       input int f4, input int o4);
      exp_t e;
      e.cyc = c; e.f8 = f8; e.o8 = o8; e.f4 = f4; e.o4 = o4;
      sb.push_back(e);
   endtask

   initial begin
      // clk/10 from reset: warm window discarded, then 10 per window
      mode = 1; per = 10; en = 1'b1;
      do_reset(3);
      chk("rst_freq8", int'(freq8), 0);
      chk("rst_valid8", int'(valid8), 0);
      chk("rst_ovf8", int'(ovf8), 0);
      chk("rst_freq4", int'(freq4), 0);
      push(200, 10, 0, 10, 0);
      push(300, 10, 0, 10, 0);
      go_to(349);
      // en low for edges 350..369; fresh warm window starts at edge 370
      en = 1'b0;
      go_to(360);
      chk("en_low_freq_hold", int'(freq8), 10);
      chk("en_low_valid", int'(valid8), 0);
      go_to(369);
      en = 1'b1;
      push(569, 10, 0, 10, 0);
      go_to(649);
      // one-cycle reset mid-window
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_freq8", int'(freq8), 10 * 0);
      chk("midrst_ovf8", int'(ovf8), 0);
      chk("midrst_valid8", int'(valid8), 0);
      reset = 1'b0;
      push(200, 10, 0, 10, 0);
      go_to(210);

      // sig_in high through reset: spurious edge falls in warm window
      mode = 0; lvl = 1'b1;
      do_reset(3);
      push(200, 0, 0, 0, 0);
      go_to(210);

      // clk/4: 25 edges per window, W=4 saturates at 15
      mode = 1; per = 4;
      do_reset(3);
      push(200, 25, 0, 15, 1);
      push(300, 25, 0, 15, 1);
      go_to(310);

      // clk/8: 100/8 windows alternate 12 and 13 with this phase
      mode = 1; per = 8;
      do_reset(3);
      push(200, 12, 0, 12, 0);
      push(300, 13, 0, 13, 0);
      go_to(310);

      // single pulse detected exactly on the end-of-window cycle (edge 200)
      mode = 2; pulse_k = 198;
      do_reset(3);
      push(200, 1, 0, 1, 0);
      push(300, 0, 0, 0, 0);
      go_to(310);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
